fsmc_bus_ctrl: RTL and testbench

Transaction controller between the FSMC front-end's internal protocol (one-hot `cs`, `addr_en`, data-valid pulse, read-active level) and up to `NUM_MODULES` user modules. It latches the address, turns each MCU write or read into a single req/ack transaction on the selected module, and places the read word on `mcu_rdata` for the front-end to drive onto AD. A timeout guards each transaction; errors are flagged and counted.

---
 rtl/fsmc_bus_ctrl.sv | 153 +++++++++++++++
 tb/tb_fsmc_bus_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsmc_bus_ctrl.sv
// FSMC transaction controller: turns front-end address/data/read events into a single
// req/ack handshake on one of NUM_MODULES user modules, with timeout and error counting.
module fsmc_bus_ctrl #(
    parameter int                    ADDR_WIDTH  = 18,
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    NUM_MODULES = 2,
    parameter int                    TIMEOUT     = 8,
    parameter logic [DATA_WIDTH-1:0] ERR_WORD    = 16'hDEAD
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [2**(ADDR_WIDTH-DATA_WIDTH)-1:0]   bus_cs,
    input  logic                                    bus_addr_en,
    input  logic [DATA_WIDTH-1:0]                   bus_data,
    input  logic                                    bus_wdata_vld,
    input  logic                                    bus_rd_act,
    output logic [DATA_WIDTH-1:0]                   mcu_rdata,
    output logic [NUM_MODULES-1:0]                  slv_req,
    output logic                                    slv_we,
    output logic [DATA_WIDTH-1:0]                   slv_addr,
    output logic [DATA_WIDTH-1:0]                   slv_wdata,
    input  logic [NUM_MODULES-1:0]                  slv_ack,
    input  logic [NUM_MODULES-1:0][DATA_WIDTH-1:0]  slv_rdata,
    output logic                                    busy,
    output logic                                    err_pulse,
    output logic [7:0]                              err_cnt
);
    localparam int CS_W  = 2**(ADDR_WIDTH-DATA_WIDTH);
    localparam int IDX_W = (CS_W > 1) ? $clog2(CS_W) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ADDR, WREQ, RREQ} state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt, cs_idx;
    logic                   vld, vld_nxt, cs_vld;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   rd_q, rd_rise;
    logic                   ack_sel;
    logic [DATA_WIDTH-1:0]  rdata_sel;
    logic [DATA_WIDTH-1:0]  rdata_nxt, addr_nxt, wdata_nxt;
    logic                   we_nxt, err_nxt;
    logic [NUM_MODULES-1:0] req_nxt;

    assign rd_rise = bus_rd_act & ~rd_q;

    // Lowest set bit of bus_cs wins; ack/rdata are muxed from the latched index.
    always_comb begin
        cs_idx = '0;
        for (int i = CS_W - 1; i >= 0; i--)
            if (bus_cs[i]) cs_idx = IDX_W'(i);
        cs_vld    = (bus_cs != '0) && (int'(cs_idx) < NUM_MODULES);
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int m = 0; m < NUM_MODULES; m++)
            if (int'(idx) == m) begin
                ack_sel   = slv_ack[m];
                rdata_sel = slv_rdata[m];
            end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        vld_nxt   = vld;
        cnt_nxt   = cnt;
        rdata_nxt = mcu_rdata;
        addr_nxt  = slv_addr;
        wdata_nxt = slv_wdata;
        we_nxt    = slv_we;
        err_nxt   = 1'b0;
        case (state)
            IDLE: if (bus_addr_en) begin
                addr_nxt = bus_data; idx_nxt = cs_idx; vld_nxt = cs_vld;
                state_nxt = ADDR;
            end
            ADDR: begin
                if (bus_addr_en) begin
                    addr_nxt = bus_data; idx_nxt = cs_idx; vld_nxt = cs_vld;
                end else if (bus_wdata_vld) begin
                    if (vld) begin
                        wdata_nxt = bus_data; we_nxt = 1'b1; cnt_nxt = '0;
                        state_nxt = WREQ;
                        err_nxt   = rd_rise;   // simultaneous read loses to the write
                    end else begin
                        err_nxt = 1'b1; state_nxt = IDLE;
                    end
                end else if (rd_rise) begin
                    if (vld) begin
                        we_nxt = 1'b0; cnt_nxt = '0; state_nxt = RREQ;
                    end else begin
                        err_nxt = 1'b1; rdata_nxt = ERR_WORD; state_nxt = IDLE;
                    end
                end
            end
            WREQ, RREQ: begin
                cnt_nxt = cnt + 1'b1;
                if (ack_sel) begin
                    if (state == RREQ) rdata_nxt = rdata_sel;
                    state_nxt = IDLE;
                    if (bus_addr_en) begin
                        addr_nxt = bus_data; idx_nxt = cs_idx; vld_nxt = cs_vld;
                        state_nxt = ADDR;
                    end
                end else if (bus_addr_en) begin
                    err_nxt  = 1'b1;
                    addr_nxt = bus_data; idx_nxt = cs_idx; vld_nxt = cs_vld;
                    state_nxt = ADDR;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    err_nxt = 1'b1;
                    if (state == RREQ) rdata_nxt = ERR_WORD;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        req_nxt = '0;
        for (int m = 0; m < NUM_MODULES; m++)
            req_nxt[m] = ((state_nxt == WREQ) || (state_nxt == RREQ)) && (int'(idx_nxt) == m);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            vld       <= 1'b0;
            cnt       <= '0;
            rd_q      <= 1'b0;
            mcu_rdata <= '0;
            slv_req   <= '0;
            slv_we    <= 1'b0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            busy      <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            vld       <= vld_nxt;
            cnt       <= cnt_nxt;
            rd_q      <= bus_rd_act;
            mcu_rdata <= rdata_nxt;
            slv_req   <= req_nxt;
            slv_we    <= we_nxt;
            slv_addr  <= addr_nxt;
            slv_wdata <= wdata_nxt;
            busy      <= (state_nxt == WREQ) || (state_nxt == RREQ);
            err_pulse <= err_nxt;
            if (err_nxt && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_fsmc_bus_ctrl.sv
// Bench for fsmc_bus_ctrl: directed scenarios, a transaction-level reference model
// compared every cycle, and literal spot checks of the documented scenarios.
module tb_fsmc_bus_ctrl;
    localparam int          AW = 18, DW = 16, NM = 2, TO = 8;
    localparam logic [15:0] ERRW = 16'hDEAD;

    logic               clk = 1'b0, rst_n = 1'b0;
    logic [3:0]         bus_cs = '0;
    logic               bus_addr_en = 1'b0, bus_wdata_vld = 1'b0, bus_rd_act = 1'b0;
    logic [DW-1:0]      bus_data = '0;
    logic [DW-1:0]      mcu_rdata, slv_addr, slv_wdata;
    logic [NM-1:0]      slv_req;
    logic               slv_we, busy, err_pulse;
    logic [7:0]         err_cnt;
    logic [NM-1:0]      slv_ack = '0;
    logic [NM-1:0][DW-1:0] slv_rdata = '0;

    int tests = 0, fails = 0;

    fsmc_bus_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_MODULES(NM), .TIMEOUT(TO),
                    .ERR_WORD(ERRW)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus_cs(bus_cs), .bus_addr_en(bus_addr_en),
        .bus_data(bus_data), .bus_wdata_vld(bus_wdata_vld), .bus_rd_act(bus_rd_act),
        .mcu_rdata(mcu_rdata), .slv_req(slv_req), .slv_we(slv_we), .slv_addr(slv_addr),
        .slv_wdata(slv_wdata), .slv_ack(slv_ack), .slv_rdata(slv_rdata), .busy(busy),
        .err_pulse(err_pulse), .err_cnt(err_cnt));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails < 40) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: tracks at most one outstanding transaction and its age.
    logic [15:0] e_rdata, e_addr, e_wdata;
    logic [1:0]  e_req;
    logic        e_we, e_busy, e_err;
    logic [7:0]  e_cnt;
    int          kind, age, a_idx;   // kind: 0 none, 1 write, 2 read
    bit          have, a_ok, rd_prev, rise;

    function automatic int low_idx(input logic [3:0] cs);
        logic [3:0] l;
        l = cs & (~cs + 4'd1);
        return $clog2(l);
    endfunction

    task automatic take_addr();
        have   = 1;
        e_addr = bus_data;
        a_idx  = low_idx(bus_cs);
        a_ok   = (bus_cs != 0) && (a_idx < NM);
    endtask

    task automatic model_step();
        if (!rst_n) begin
            e_rdata = 0; e_addr = 0; e_wdata = 0; e_req = 0; e_we = 0; e_busy = 0;
            e_err = 0; e_cnt = 0; kind = 0; age = 0; a_idx = 0; have = 0; a_ok = 0;
            rd_prev = 0;
            return;
        end
        rise = bus_rd_act && !rd_prev;
        rd_prev = bus_rd_act;
        e_err = 0;
        if (kind != 0) begin
            age++;
            if (slv_ack[a_idx]) begin
                if (kind == 2) e_rdata = slv_rdata[a_idx];
                kind = 0; have = 0;
                if (bus_addr_en) take_addr();
            end else if (bus_addr_en) begin
                e_err = 1; kind = 0; take_addr();
            end else if (age == TO) begin
                e_err = 1; kind = 0; have = 0;
                if (e_we == 0) e_rdata = ERRW;
            end
        end else if (have) begin
            if (bus_addr_en) take_addr();
            else if (bus_wdata_vld) begin
                if (a_ok) begin kind = 1; age = 0; e_we = 1; e_wdata = bus_data; e_err = rise; end
                else begin e_err = 1; have = 0; end
            end else if (rise) begin
                if (a_ok) begin kind = 2; age = 0; e_we = 0; end
                else begin e_err = 1; e_rdata = ERRW; have = 0; end
            end
        end else if (bus_addr_en) take_addr();
        if (e_err && e_cnt != 8'd255) e_cnt++;
        e_req  = (kind != 0) ? 2'(1 << a_idx) : 2'b00;
        e_busy = (kind != 0);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("outputs", {3'b0, mcu_rdata, slv_req, slv_we, slv_addr, slv_wdata, busy, err_pulse, err_cnt},
                       {3'b0, e_rdata, e_req, e_we, e_addr, e_wdata, e_busy, e_err, e_cnt});
    end

    task automatic cyc();
        @(posedge clk); #2;
    endtask

    task automatic addr(input logic [3:0] cs, input logic [15:0] a);
        bus_cs = cs; bus_data = a; bus_addr_en = 1'b1;
        cyc();
        bus_addr_en = 1'b0;
    endtask

    task automatic good_read(input logic [3:0] cs, input logic [15:0] a, input int m,
                             input logic [15:0] d);
        addr(cs, a);
        bus_rd_act = 1'b1;
        cyc();
        slv_ack[m] = 1'b1; slv_rdata[m] = d;
        cyc();
        slv_ack = '0; bus_rd_act = 1'b0;
        cyc();
    endtask

    int nreq, nerr;

    initial begin
        cyc(); cyc();
        chk("reset_outputs", {mcu_rdata, slv_req, slv_we, slv_addr, slv_wdata, busy, err_pulse, err_cnt}, 0);
        rst_n = 1'b1;
        cyc();

        // write to module 1, ack three cycles later
        addr(4'b0010, 16'h0012);
        bus_data = 16'hA5A5; bus_wdata_vld = 1'b1;
        cyc();
        bus_wdata_vld = 1'b0;
        chk("wr_req", slv_req, 2'b10);
        chk("wr_we", slv_we, 1'b1);
        chk("wr_addr", slv_addr, 16'h0012);
        chk("wr_wdata", slv_wdata, 16'hA5A5);
        cyc(); cyc();
        slv_ack = 2'b10;
        cyc();
        slv_ack = '0;
        chk("wr_req_drop", slv_req, 2'b00);
        chk("wr_no_err", {err_pulse, err_cnt}, 9'd0);
        cyc();

        // read of module 0 acked one cycle after the rise
        addr(4'b0001, 16'h0003);
        bus_rd_act = 1'b1;
        cyc();
        chk("rd_busy", busy, 1'b1);
        slv_ack = 2'b01; slv_rdata[0] = 16'h1234;
        cyc();
        slv_ack = '0;
        chk("rd_data", mcu_rdata, 16'h1234);
        chk("rd_busy_drop", busy, 1'b0);
        bus_rd_act = 1'b0;
        cyc();

        // read timeout on module 1
        addr(4'b0010, 16'h0005);
        bus_rd_act = 1'b1;
        cyc();
        nreq = 0; nerr = 0;
        for (int i = 0; i < 12; i++) begin
            if (slv_req == 2'b10) nreq++;
            if (err_pulse) nerr++;
            cyc();
        end
        bus_rd_act = 1'b0;
        chk("to_req_cycles", nreq, TO);
        chk("to_err_pulses", nerr, 1);
        chk("to_rdata", mcu_rdata, 16'hDEAD);
        chk("to_err_cnt", err_cnt, 8'd1);
        cyc();

        // invalid select after a good read has replaced the error word
        good_read(4'b0001, 16'h0009, 0, 16'h4321);
        chk("rd2_data", mcu_rdata, 16'h4321);
        addr(4'b0100, 16'h0007);
        bus_rd_act = 1'b1;
        nreq = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (slv_req != 0) nreq++;
        end
        bus_rd_act = 1'b0;
        chk("inv_no_req", nreq, 0);
        chk("inv_rdata", mcu_rdata, 16'hDEAD);
        chk("inv_err_cnt", err_cnt, 8'd2);
        cyc();

        // abort: new address during WREQ
        addr(4'b0010, 16'h0020);
        bus_data = 16'h1111; bus_wdata_vld = 1'b1;
        cyc();
        bus_wdata_vld = 1'b0;
        cyc();
        addr(4'b0010, 16'h0030);
        chk("abort_req", slv_req, 2'b00);
        chk("abort_err", err_pulse, 1'b1);
        chk("abort_addr", slv_addr, 16'h0030);
        chk("abort_cnt", err_cnt, 8'd3);

        // new address in the ack cycle: completes cleanly
        bus_data = 16'h2222; bus_wdata_vld = 1'b1;
        cyc();
        bus_wdata_vld = 1'b0;
        slv_ack = 2'b10;
        addr(4'b0010, 16'h0040);
        slv_ack = '0;
        chk("ackaddr_err", {err_pulse, err_cnt}, {1'b0, 8'd3});
        chk("ackaddr_addr", slv_addr, 16'h0040);
        chk("ackaddr_req", slv_req, 2'b00);

        // ack from the wrong module is ignored
        bus_data = 16'h3333; bus_wdata_vld = 1'b1;
        cyc();
        bus_wdata_vld = 1'b0;
        slv_ack = 2'b01;
        cyc();
        slv_ack = '0;
        chk("wrongack_req", slv_req, 2'b10);
        slv_ack = 2'b10;
        cyc();
        slv_ack = '0;
        chk("rightack_req", {slv_req, err_cnt}, {2'b00, 8'd3});
        cyc();

        // write and read rise together: write serviced, read flagged
        addr(4'b0001, 16'h0050);
        bus_data = 16'h7777; bus_wdata_vld = 1'b1; bus_rd_act = 1'b1;
        cyc();
        bus_wdata_vld = 1'b0;
        chk("coll_state", {slv_req, slv_we, err_pulse, slv_wdata}, {2'b01, 1'b1, 1'b1, 16'h7777});
        chk("coll_rdata", mcu_rdata, 16'hDEAD);
        slv_ack = 2'b01;
        cyc();
        slv_ack = '0; bus_rd_act = 1'b0;
        chk("coll_cnt", err_cnt, 8'd4);
        cyc();

        // saturate the error counter with repeated timeouts
        for (int n = 0; n < 260; n++) begin
            addr(4'b0010, 16'(n));
            bus_rd_act = 1'b1;
            for (int i = 0; i < 9; i++) cyc();
            bus_rd_act = 1'b0;
            cyc();
        end
        chk("sat_cnt", err_cnt, 8'd255);

        // asynchronous reset in the middle of a read
        addr(4'b0001, 16'h0001);
        bus_rd_act = 1'b1;
        cyc();
        chk("rst_pre_req", slv_req, 2'b01);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async", {mcu_rdata, slv_req, slv_we, slv_addr, slv_wdata, busy, err_pulse, err_cnt}, 0);
        cyc();
        rst_n = 1'b1; bus_rd_act = 1'b0;
        cyc(); cyc();
        chk("rst_idle", {slv_req, busy}, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
